// File: rtl/con_pkg.sv
// ----------------------------------------------------------------------------
// con_pkg : condition encodings and FSM state type for the CON unit
// Rev 1.0 : initial parametrised release
// ----------------------------------------------------------------------------
`default_nettype none

package con_pkg;

   localparam logic [2:0] COND_ZERO   = 3'b000;
   localparam logic [2:0] COND_NZERO  = 3'b001;
   localparam logic [2:0] COND_POS    = 3'b010;
   localparam logic [2:0] COND_NEG    = 3'b011;
   localparam logic [2:0] COND_ALWAYS = 3'b100;
   localparam logic [2:0] COND_NEVER  = 3'b101;
   localparam logic [2:0] COND_CARRY  = 3'b110;
   localparam logic [2:0] COND_OVF    = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      HOLD = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/con_ff_unit_if.sv
// ----------------------------------------------------------------------------
// con_ff_unit_if : request/result signals between control unit and CON unit
// Rev 1.0 : initial parametrised release
// ----------------------------------------------------------------------------
`default_nettype none

interface con_ff_unit_if #(
   parameter int DATA_WIDTH = 32,
   parameter int IR_WIDTH   = 32
);
   logic                  con_in;
   logic [IR_WIDTH-1:0]   ir_in;
   logic [DATA_WIDTH-1:0] bus_in;
   logic                  flag_wr;
   logic                  carry_in;
   logic                  ovf_in;
   logic                  con_ack;
   logic                  con_out;
   logic                  con_valid;
   logic                  busy;
   logic                  drop_err;

   modport master (
      output con_in, ir_in, bus_in, flag_wr, carry_in, ovf_in, con_ack,
      input  con_out, con_valid, busy, drop_err
   );

   modport slave (
      input  con_in, ir_in, bus_in, flag_wr, carry_in, ovf_in, con_ack,
      output con_out, con_valid, busy, drop_err
   );
endinterface

`default_nettype wire

// File: rtl/con_eval.sv
// ----------------------------------------------------------------------------
// con_eval : combinational branch-condition evaluator (cond, operand, C, V)
// Rev 1.0 : initial parametrised release
// ----------------------------------------------------------------------------
`default_nettype none

module con_eval
   import con_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [2:0]            cond,
   input  logic [DATA_WIDTH-1:0] operand,
   input  logic                  carry,
   input  logic                  ovf,
   output logic                  result
);

   logic w_is_zero;
   logic w_msb;

   assign w_is_zero = (operand == '0);
   assign w_msb     = operand[DATA_WIDTH-1];

   always_comb begin
      result = 1'b0;
      case (cond)
         COND_ZERO:   result = w_is_zero;
         COND_NZERO:  result = ~w_is_zero;
         COND_POS:    result = ~w_msb;
         COND_NEG:    result = w_msb;
         COND_ALWAYS: result = 1'b1;
         COND_NEVER:  result = 1'b0;
         COND_CARRY:  result = carry;
         COND_OVF:    result = ovf;
         default:     result = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/con_ff_unit.sv
// ----------------------------------------------------------------------------
// con_ff_unit : registered branch-condition unit with valid/ack result return
// Rev 1.0 : initial parametrised release
// ----------------------------------------------------------------------------
`default_nettype none

module con_ff_unit
   import con_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int IR_WIDTH   = 32,
   parameter int COND_LSB   = 19
) (
   input  logic          clk,
   input  logic          clear,
   con_ff_unit_if.slave  cu
);

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_capture;
   logic                  w_result;

   logic [2:0]            r_cond;
   logic [DATA_WIDTH-1:0] r_operand;
   logic                  r_snap_c;
   logic                  r_snap_v;
   logic                  r_flag_c;
   logic                  r_flag_v;
   logic                  r_con_out;
   logic                  r_drop_err;

   // Evaluation sees only the snapshot, so later bus/IR/flag changes are inert.
   con_eval #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_eval (
      .cond    (r_cond),
      .operand (r_operand),
      .carry   (r_snap_c),
      .ovf     (r_snap_v),
      .result  (w_result)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      case (r_state)
         IDLE: begin
            if (cu.con_in) begin
               w_capture   = 1'b1;
               w_state_nxt = EVAL;
            end
         end
         EVAL:    w_state_nxt = HOLD;
         HOLD:    if (cu.con_ack) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         r_state    <= IDLE;
         r_cond     <= '0;
         r_operand  <= '0;
         r_snap_c   <= 1'b0;
         r_snap_v   <= 1'b0;
         r_flag_c   <= 1'b0;
         r_flag_v   <= 1'b0;
         r_con_out  <= 1'b0;
         r_drop_err <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_capture) begin
            r_cond    <= cu.ir_in[COND_LSB+2:COND_LSB];
            r_operand <= cu.bus_in;
            r_snap_c  <= r_flag_c;
            r_snap_v  <= r_flag_v;
         end
         if (cu.flag_wr) begin
            r_flag_c <= cu.carry_in;
            r_flag_v <= cu.ovf_in;
         end
         if (r_state == EVAL) begin
            r_con_out <= w_result;
         end
         if (cu.con_in && (r_state != IDLE)) begin
            r_drop_err <= 1'b1;
         end
      end
   end

   assign cu.con_out   = r_con_out;
   assign cu.con_valid = (r_state == HOLD);
   assign cu.busy      = (r_state != IDLE);
   assign cu.drop_err  = r_drop_err;

endmodule

`default_nettype wire

// File: doc/con_ff_unit.md
Name: con_ff_unit

Overview:
Parametrised branch-condition unit for the CPU datapath, the successor to the fixed 32-bit CON flip-flop logic. It decodes a 3-bit condition field from the instruction register and evaluates it against a bus operand and a stored carry/overflow flag register. It registers the CON result and returns it to the control unit through a valid/ack handshake. It sits between the IR, the bus mux output and the control unit's branch sequencing.

Parameters:
DATA_WIDTH, 32, width of bus operand evaluated
IR_WIDTH, 32, instruction register width
COND_LSB, 19, bit position of LSB of 3-bit condition field in IR (field = ir_in[COND_LSB+2:COND_LSB])

Ports:
clk  in  1  system clock, rising edge
clear  in  1  synchronous active-high reset
con_in  in  1  request evaluation (legacy "enable")
ir_in  in  IR_WIDTH  instruction register contents
bus_in  in  DATA_WIDTH  bus mux output operand
flag_wr  in  1  load carry/overflow flag register
carry_in  in  1  ALU carry, loaded on flag_wr
ovf_in  in  1  ALU overflow, loaded on flag_wr
con_ack  in  1  control unit consumed result
con_out  out  1  registered branch condition result
con_valid  out  1  con_out is fresh, held until acked
busy  out  1  FSM not in IDLE
drop_err  out  1  sticky: con_in seen while busy

Behaviour:
- Reset: clk and clear, one clock, synchronous active-high; clear overrides all other inputs. All outputs 0, flags C=V=0, FSM=IDLE, snapshot registers 0.
- Condition codes (cond[2:0]): 000 zero (bus==0); 001 nonzero; 010 positive (bus MSB==0, zero counts as positive); 011 negative (MSB==1); 100 always 1; 101 never 0; 110 carry set (C); 111 overflow set (V). Codes 000-011 match legacy 2-bit behaviour.
- Flag register: on flag_wr, C<=carry_in, V<=ovf_in, in any FSM state.
- FSM states IDLE, EVAL, HOLD:
  - IDLE: busy=0. If con_in=1 at edge N, capture cond, bus_in, C, V into snapshot registers, go to EVAL.
  - EVAL (cycle N+1): compute result from snapshot only. At edge N+1, con_out<=result, con_valid<=1, go to HOLD.
  - HOLD: con_valid=1 from N+2 until con_ack sampled high. con_ack at edge M returns to IDLE; con_valid=0 from M+1.
- Latency: con_in to con_valid is exactly 2 cycles. Minimum request-to-request spacing is 3 cycles (ack in first HOLD cycle).
- con_out keeps its last value after ack until the next EVAL completes.
- con_ack in IDLE or EVAL: ignored.
- con_in while busy: ignored (no queueing), drop_err<=1. drop_err is sticky until clear.
- flag_wr and con_in in the same IDLE cycle: the snapshot takes the pre-update C/V. New flags apply to the next request.
- bus_in and ir_in changes after capture do not affect the result.
- clear in EVAL/HOLD: aborts. Next cycle is IDLE with all outputs 0 and the pending result discarded.
- No combinational path from any input to any output.

Decomposition:
- Package con_pkg: localparam condition encodings (COND_ZERO..COND_OVF), FSM state enum (IDLE/EVAL/HOLD, 2 bits).
- One natural sub-module: con_eval, a purely combinational condition evaluator (cond, operand, C, V -> result), parametrised by DATA_WIDTH. It is reusable by the control unit for prediction.

Test Plan:
- Legacy vector: clear 1 cycle; ir_in=0xA50F00FF (cond=001), bus_in=0xFFF0F0F5, con_in pulse at N -> con_valid=1, con_out=1 at N+2; con_ack at N+3 -> con_valid=0 at N+4, con_out stays 1.
- Sweep codes 000-011 with bus_in=0 and 0x80000000: zero -> 1/0, nonzero -> 0/1, positive -> 1/0, negative -> 0/1. Codes 100/101 -> 1/0 regardless of bus.
- Flags: flag_wr with carry_in=1, ovf_in=0, then request cond 110 -> con_out=1, cond 111 -> 0. Same-cycle flag_wr(C=0) + con_in(cond 110) after C=1 -> con_out=1.
- Busy drop: con_in again at N+1 with a different IR -> result reflects the first request only, drop_err=1 and sticky until clear.
- Hold: withhold con_ack 10 cycles -> con_valid remains 1 and con_out stable. Bus/IR changes during hold have no effect.
- Reset mid-op: clear at N+1 after con_in -> at N+2 con_valid=0, con_out=0, busy=0, drop_err=0. A new request then completes normally in 2 cycles.
